// File: rtl/fifo_wr_arbiter_if.sv
// Purpose : Bundles the producer handshake and the FIFO write-port signals of
//           fifo_wr_arbiter into one interface.
// Signals :
//   req_valid_i     [NUM_REQ]          per-producer beat valid
//   req_data_i      [NUM_REQ*DSIZE]    producer i data at [i*DSIZE +: DSIZE]
//   req_ready_o     [NUM_REQ]          per-producer ready (combinational)
//   grant_o         [NUM_REQ]          one-hot current grant (registered)
//   fifo_wr_data_o  [DSIZE]            FIFO write data (registered)
//   fifo_wr_req_o                      FIFO write request (registered)
//   fifo_full_i                        FIFO full flag
//   fifo_occupied_i [$clog2(DEPTH)+1]  FIFO write-side occupancy
// Modports: slave = arbiter side, master = producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned DEPTH   = 16
);
  localparam int unsigned OW = $clog2(DEPTH) + 1;

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*DSIZE-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       grant_o;
  logic [DSIZE-1:0]         fifo_wr_data_o;
  logic                     fifo_wr_req_o;
  logic                     fifo_full_i;
  logic [OW-1:0]            fifo_occupied_i;

  modport slave (
    input  req_valid_i, req_data_i, fifo_full_i, fifo_occupied_i,
    output req_ready_o, grant_o, fifo_wr_data_o, fifo_wr_req_o
  );

  modport master (
    output req_valid_i, req_data_i, fifo_full_i, fifo_occupied_i,
    input  req_ready_o, grant_o, fifo_wr_data_o, fifo_wr_req_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Purpose : Round-robin arbiter sharing the write port of a FIFO among NUM_REQ
//           producers. Grants one producer per burst of up to MAX_BURST beats,
//           registers each accepted beat onto the FIFO write port, and throttles
//           on occupancy plus writes not yet visible in fifo_occupied_i so the
//           FIFO never holds more than DEPTH-HEADROOM entries.
// Ports   :
//   wr_clk    in  write-domain clock
//   wr_reset  in  synchronous active-high reset
//   bus       slave modport of fifo_wr_arbiter_if (producer + FIFO signals)
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned HEADROOM  = 2,
  parameter int unsigned OCC_LAT   = 2
) (
  input  logic              wr_clk,
  input  logic              wr_reset,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int unsigned IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SW    = $clog2(DEPTH) + 2;
  localparam int unsigned CW    = $clog2(MAX_BURST + 1);
  localparam int unsigned PW    = $clog2(OCC_LAT + 1);
  localparam int unsigned LIMIT = DEPTH - HEADROOM;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             r_state,     w_state_nxt;
  logic [NUM_REQ-1:0] r_grant,     w_grant_nxt;
  logic [IW-1:0]      r_ptr,       w_ptr_nxt;
  logic [IW-1:0]      r_gidx,      w_gidx_nxt;
  logic [CW-1:0]      r_burst_cnt, w_burst_cnt_nxt;
  logic [OCC_LAT-1:0] r_pend_sr;
  logic               r_wr_req;
  logic [DSIZE-1:0]   r_wr_data;

  logic [PW-1:0]      w_pending;
  logic [SW-1:0]      w_sum;
  logic               w_space_ok;
  logic [IW-1:0]      w_cand [NUM_REQ];
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_vld;
  logic               w_xfer;
  logic [NUM_REQ-1:0] w_ready;
  logic [DSIZE-1:0]   w_beat;

  // Writes issued in the last OCC_LAT cycles are not yet reflected in occupancy.
  always_comb begin
    w_pending = '0;
    for (int unsigned k = 0; k < OCC_LAT; k++) begin
      w_pending = w_pending + PW'(r_pend_sr[k]);
    end
  end

  // Conservative fill estimate, one bit wider than occupancy so it cannot wrap.
  always_comb begin
    w_sum      = SW'(bus.fifo_occupied_i) + SW'(w_pending) + SW'(r_wr_req);
    w_space_ok = !bus.fifo_full_i && (w_sum < SW'(LIMIT));
  end

  // Round-robin pick: first valid index after the last-grant pointer, wrapping.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand[k] = IW'((32'(r_ptr) + k + 1) % NUM_REQ);
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_pick_vld && bus.req_valid_i[w_cand[k]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand[k];
      end
    end
  end

  // One-hot data select of the granted producer.
  always_comb begin
    w_beat = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_beat = w_beat | bus.req_data_i[k*DSIZE +: DSIZE];
      end
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_gidx_nxt      = r_gidx;
    w_burst_cnt_nxt = r_burst_cnt;
    w_ready         = '0;
    w_xfer          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        if (w_pick_vld && w_space_ok) begin
          w_state_nxt     = S_BURST;
          w_grant_nxt     = NUM_REQ'(1) << w_pick_idx;
          w_gidx_nxt      = w_pick_idx;
          w_burst_cnt_nxt = '0;
        end
      end
      S_BURST: begin
        // Lack of space only stalls; grant and count are kept.
        w_ready = r_grant & {NUM_REQ{w_space_ok}};
        w_xfer  = w_space_ok && bus.req_valid_i[r_gidx];
        if (!bus.req_valid_i[r_gidx] ||
            (w_xfer && (r_burst_cnt == CW'(MAX_BURST - 1)))) begin
          w_state_nxt     = S_IDLE;
          w_grant_nxt     = '0;
          w_ptr_nxt       = r_gidx;
          w_burst_cnt_nxt = '0;
        end else if (w_xfer) begin
          w_burst_cnt_nxt = r_burst_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_ptr       <= IW'(NUM_REQ - 1);
      r_gidx      <= '0;
      r_burst_cnt <= '0;
      r_pend_sr   <= '0;
      r_wr_req    <= 1'b0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gidx      <= w_gidx_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_pend_sr   <= (r_pend_sr << 1) | OCC_LAT'(r_wr_req);
      r_wr_req    <= w_xfer;
      if (w_xfer) begin
        r_wr_data <= w_beat;
      end
    end
  end

  assign bus.req_ready_o    = w_ready;
  assign bus.grant_o        = r_grant;
  assign bus.fifo_wr_req_o  = r_wr_req;
  assign bus.fifo_wr_data_o = r_wr_data;

endmodule
